// File: rtl/imem_load_ctrl.sv
// Instruction-memory boot/reload controller: streams program words into consecutive
// word addresses, holds the core in reset until a full image is loaded, decodes fetch PCs.
module imem_load_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int PC_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              fetch_fault,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        ERR
    } state_t;

    state_t          state, state_nxt;
    logic [ADDR_W:0] count_nxt;
    logic            accept;
    logic            at_last_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            word_count <= '0;
        end else begin
            state      <= state_nxt;
            word_count <= count_nxt;
        end
    end

    // word_count stays below DEPTH while in LOAD, so the low bits are the write index
    assign accept      = ld_valid && (state == LOAD);
    assign at_last_idx = (word_count[ADDR_W-1:0] == '1);

    always_comb begin
        state_nxt = state;
        count_nxt = word_count;
        unique case (state)
            IDLE, RUN, ERR: begin
                if (start_load) begin
                    state_nxt = LOAD;
                    count_nxt = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    count_nxt = word_count + (ADDR_W+1)'(1);
                    if (ld_last)
                        state_nxt = RUN;
                    else if (at_last_idx)
                        state_nxt = ERR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_ready   = (state == LOAD);
        core_hold  = (state != RUN);
        load_done  = (state == RUN);
        load_error = (state == ERR);
        mem_we     = accept;
        mem_waddr  = word_count[ADDR_W-1:0];
        mem_wdata  = ld_data;
    end

    assign mem_raddr   = fetch_pc[ADDR_W+1:2];
    assign fetch_fault = (state != RUN) || (fetch_pc[1:0] != 2'b00)
                       || (|fetch_pc[PC_W-1:ADDR_W+2]);

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized self-checking bench for imem_load_ctrl against a behavioural loader model.
module tb_imem_load_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int PC_W   = 64;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_load = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_last = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic [PC_W-1:0]   fetch_pc = '0;
    logic              ld_ready, mem_we, fetch_fault, core_hold, load_done, load_error;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W:0]   word_count;

    int checks = 0;
    int errors = 0;

    // model: loading / image valid / overflowed, plus words taken by the current load
    bit          m_load, m_run, m_err;
    int          m_cnt;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] tb_mem[DEPTH];

    imem_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .start_load(start_load), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .fetch_pc(fetch_pc),
        .mem_raddr(mem_raddr), .fetch_fault(fetch_fault), .core_hold(core_hold),
        .load_done(load_done), .load_error(load_error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) tb_mem[mem_waddr] <= mem_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_mem();
        for (int i = 0; i < m_cnt && i < DEPTH; i++)
            check("mem_content", tb_mem[i], m_mem[i]);
    endtask

    // One clock: compare outputs at the falling edge, advance the model at the rising edge
    task automatic cycle();
        bit acc, exp_fault;
        @(negedge clk);
        acc       = ld_valid && m_load;
        exp_fault = !m_run || (fetch_pc % 4 != 0) || (fetch_pc >= 64'(DEPTH * 4));
        check("ld_ready",    ld_ready,    m_load);
        check("core_hold",   core_hold,   !m_run);
        check("load_done",   load_done,   m_run);
        check("load_error",  load_error,  m_err);
        check("mem_we",      mem_we,      acc);
        check("word_count",  word_count,  m_cnt);
        check("mem_raddr",   mem_raddr,   (fetch_pc / 4) % DEPTH);
        check("fetch_fault", fetch_fault, exp_fault);
        if (acc) begin
            check("mem_waddr", mem_waddr, m_cnt % DEPTH);
            check("mem_wdata", mem_wdata, ld_data);
        end
        @(posedge clk);
        if (m_load) begin
            if (acc) begin
                m_mem[m_cnt % DEPTH] = ld_data;
                m_cnt++;
                if (ld_last) begin
                    m_load = 0;
                    m_run  = 1;
                end else if (m_cnt == DEPTH) begin
                    m_load = 0;
                    m_err  = 1;
                end
            end
        end else if (start_load) begin
            m_load = 1;
            m_run  = 0;
            m_err  = 0;
            m_cnt  = 0;
        end
        #1;
    endtask

    task automatic drive(input bit s, input bit v, input bit l, input logic [31:0] d);
        start_load = s;
        ld_valid   = v;
        ld_last    = l;
        ld_data    = d;
        cycle();
    endtask

    task automatic do_reset();
        start_load = 0;
        ld_valid   = 0;
        ld_last    = 0;
        fetch_pc   = '0;
        rst        = 0;
        #2;
        check("rst_core_hold", core_hold,   1);
        check("rst_ld_ready",  ld_ready,    0);
        check("rst_mem_we",    mem_we,      0);
        check("rst_count",     word_count,  0);
        check("rst_fault",     fetch_fault, 1);
        check("rst_done",      load_done,   0);
        m_load = 0;
        m_run  = 0;
        m_err  = 0;
        m_cnt  = 0;
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit prev_run;
        #3;
        do_reset();

        // normal three-word program
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 32'h00700013);
        drive(0, 1, 0, 32'h0BA00193);
        drive(0, 1, 1, 32'h00400693);
        check("t2_done",  load_done,  1);
        check("t2_hold",  core_hold,  0);
        check("t2_count", word_count, 3);
        check_mem();

        // fetch decode while running
        fetch_pc = 64'h3C; #1;
        check("t5_raddr", mem_raddr,   15);
        check("t5_fault", fetch_fault, 0);
        drive(0, 0, 0, 0);
        fetch_pc = 64'h3E; #1;
        check("t5_misalign", fetch_fault, 1);
        drive(0, 0, 0, 0);
        fetch_pc = 64'h40; #1;
        check("t5_range", fetch_fault, 1);
        drive(0, 0, 0, 0);
        fetch_pc = '0;

        // valid gaps
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 32'hAAAA0001);
        drive(0, 0, 0, 32'hDEAD0000);
        drive(0, 0, 0, 32'hDEAD0001);
        drive(0, 1, 0, 32'hAAAA0002);
        check("t3_count", word_count, 2);
        check_mem();
        drive(0, 1, 1, 32'hAAAA0003);

        // reload from RUN; start_load inside LOAD is ignored
        drive(1, 0, 0, 0);
        check("t6_hold",  core_hold,  1);
        check("t6_count", word_count, 0);
        check("t6_done",  load_done,  0);
        drive(0, 1, 0, 32'h12345678);
        drive(1, 0, 0, 0);
        check("t6_ignore", word_count, 1);
        drive(1, 1, 1, 32'h9ABCDEF0);
        check("t6_done2", load_done, 1);

        // overflow, then exactly-full image
        drive(1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 0, $urandom);
        check("t4_err",   load_error, 1);
        check("t4_ready", ld_ready,   0);
        check("t4_hold",  core_hold,  1);
        check("t4_count", word_count, DEPTH);
        check_mem();
        drive(0, 1, 0, $urandom);
        check("t4_we17", mem_we, 0);
        drive(1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive(0, 1, (i == DEPTH - 1), $urandom);
        check("t4_full_done", load_done,  1);
        check("t4_full_err",  load_error, 0);
        check("t4_full_cnt",  word_count, DEPTH);
        check_mem();

        // reset in the middle of a load
        drive(1, 0, 0, 0);
        drive(0, 1, 0, $urandom);
        ld_valid = 1;
        do_reset();
        drive(0, 0, 0, 0);

        // random traffic
        prev_run = m_run;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            case ($urandom_range(0, 2))
                0:       fetch_pc = 64'($urandom_range(0, 127));
                1:       fetch_pc = {$urandom, $urandom};
                default: fetch_pc = 64'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom);
            if (m_run && !prev_run) check_mem();
            prev_run = m_run;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
